obstacle_sched: RTL and testbench
=================================

// Module: obstacle_sched
// PURPOSE
//  Schedules obstacles (trees) for the Dino game. Owns N obstacle slots: spawns at right edge with LFSR-randomised gaps,
//  scrolls them left by a level-dependent step per frame tick, retires them at x=0. Sits between the game controller
//  (run/freeze/level) and the VGA renderer (slot positions); reports collision-zone occupancy and per-obstacle pass pulses.
// PARAMETERS
//  N_SLOTS   4        number of concurrent obstacle slots (1..8)
//  POS_W     9        x-position width in pixels
//  SPAWN_X   9'd479   x loaded into a slot on spawn
//  DINO_X    9'd400   pass line; crossing it (>= to <) emits pass_pulse
//  HIT_LO    9'd401   collision window low bound (exclusive)
//  HIT_HI    9'd469   collision window high bound (exclusive)
//  MIN_GAP   8'd120   minimum pixels scrolled between spawns
//  SEED      16'hACE1 LFSR reset value (non-zero)
// PORTS
//  clk         in   1              system clock (50 MHz)
//  clr         in   1              synchronous active-high reset
//  run         in   1              game controller is in running/jump state
//  freeze      in   1              game over; hold all positions
//  level       in   2              speed level 0..3
//  frame_tick  in   1              one-cycle pulse per scroll step
//  obs_valid   out  N_SLOTS        slot i holds a live obstacle
//  obs_pos     out  N_SLOTS*POS_W  slot i x-position, slot 0 in LSBs
//  obs_kind    out  N_SLOTS        0 = small tree, 1 = large tree
//  hit_zone    out  1              some valid slot has HIT_LO < pos < HIT_HI
//  pass_pulse  out  1              one cycle: an obstacle crossed DINO_X this step
//  spawn_pulse out  1              one cycle: a slot was loaded
// BEHAVIOUR
//  - Reset (clr=1 at posedge): state=IDLE, obs_valid=0, obs_pos=0, obs_kind=0, hit_zone=0, pass/spawn_pulse=0,
//    gap_cnt=MIN_GAP, lfsr=SEED. clr overrides every other input in the same cycle.
//  - FSM: IDLE -(run & !freeze)-> RUN; RUN -(freeze)-> FROZEN; RUN -(!run & !freeze)-> IDLE;
//    FROZEN -(!run & !freeze)-> IDLE; otherwise hold. Entering IDLE clears all slots and reloads gap_cnt=MIN_GAP.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle outside reset (button timing adds entropy).
//  - Scroll (RUN & frame_tick only): step = 1+level (1..4). Each valid slot: pos<step -> valid<=0, pos<=0;
//    else pos<=pos-step. Positions change on the posedge sampling frame_tick; no wrap-around ever.
//  - pass_pulse=1 next cycle if any slot had pos>=DINO_X and new pos<DINO_X; multiple crossings in one step -> single pulse.
//  - Gap: on each scroll step gap_cnt<=sat0(gap_cnt-step). When gap_cnt==0 at a tick and a slot is free
//    (judged on valid bits BEFORE this tick's retirements), lowest-index free slot loads pos=SPAWN_X,
//    kind=lfsr[0], valid=1; gap_cnt<=MIN_GAP + lfsr[7:1] - 16*level (9-bit sum, floor MIN_GAP/2).
//    No free slot: gap_cnt stays 0, spawn pending until a later tick. A newly spawned slot is not scrolled that tick.
//  - hit_zone registered from current obs state: valid one cycle after the position update; 0 in IDLE.
//  - FROZEN: positions, kinds, valid, gap_cnt held; frame_tick ignored; hit_zone keeps last value; pulses 0.
//  - run & freeze both high in IDLE: stay IDLE. frame_tick outside RUN has no effect.
//  - Reset mid-scroll: all slots cleared that cycle, no pulse emitted.
// STRUCTURE
//  - Shared package dino_pkg: state encoding (IDLE=2'd0, RUN=2'd1, FROZEN=2'd2), SPAWN_X, DINO_X, HIT_LO/HIT_HI,
//    MIN_GAP, screen width 480; shared with game controller and renderer.
//  - One sub-module lfsr16 (clk, clr, seed, q[15:0]); slot array and priority encoder stay in this module.
// TESTING
//  1. clr for 2 cycles -> all outputs 0; run=1, 120 ticks @level0 -> spawn_pulse on tick 120, slot0 pos=479.
//  2. level=3, slot0 at 6, one tick -> pos=2; next tick -> valid0=0, pos0=0 (no wrap to 510).
//  3. slot at pos 402, level=1, one tick -> pos 400, no pass; next tick -> 398, pass_pulse=1 exactly 1 cycle.
//  4. All 4 slots valid, gap_cnt=0 -> no spawn; tick retiring slot2 -> no spawn that tick, slot2 spawns next tick.
//  5. Slot at 430, freeze=1, 50 ticks -> pos stays 430, hit_zone=1; run=0,freeze=0 -> IDLE, obs_valid=0, hit_zone=0.
//  6. clr asserted on a frame_tick cycle in RUN -> next cycle obs_valid=0, pass/spawn_pulse=0, state IDLE.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared Dino-game definitions: FSM state encoding, screen geometry, obstacle
// scheduling constants and the gap-reload helper. Imported by the game
// controller, the renderer and obstacle_sched.
// No ports (package).
package dino_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFrozen = 2'd2
  } state_e;

  localparam int unsigned PosWDef    = 9;
  localparam logic [8:0]  ScreenW    = 9'd480;
  localparam logic [8:0]  SpawnXDef  = 9'd479;
  localparam logic [8:0]  DinoXDef   = 9'd400;
  localparam logic [8:0]  HitLoDef   = 9'd401;
  localparam logic [8:0]  HitHiDef   = 9'd469;
  localparam logic [7:0]  MinGapDef  = 8'd120;
  localparam logic [15:0] SeedDef    = 16'hACE1;

  // Next spawn distance: MIN_GAP + 7 random bits - 16*level, never below MIN_GAP/2.
  function automatic logic [8:0] gap_reload(input logic [7:0] min_gap,
                                            input logic [6:0] rnd,
                                            input logic [1:0] level);
    logic [8:0] sum;
    logic [8:0] floor_v;
    sum     = {1'b0, min_gap} + {2'b00, rnd} - {3'b000, level, 4'b0000};
    floor_v = {2'b00, min_gap[7:1]};
    return (sum < floor_v) ? floor_v : sum;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every cycle it is not
// held in reset.
// Ports: i_clk clock, i_clr sync active-high reset (loads i_seed),
//        i_seed reset value (must be non-zero), o_q current register value.
module lfsr16 (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic [15:0] i_seed,
  output logic [15:0] o_q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_q <= i_seed;
    end else begin
      r_q <= {r_q[14:0], w_fb};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/obstacle_sched.sv
// Obstacle scheduler for the Dino game. Holds N_SLOTS obstacle slots, spawns
// them at the right edge after LFSR-randomised gaps, scrolls them left by
// 1+level pixels per frame tick while running, and retires them at x=0.
// Ports:
//   i_clk, i_clr         clock, synchronous active-high reset
//   i_run, i_freeze      game-controller run / game-over freeze
//   i_level              speed level 0..3
//   i_frame_tick         one-cycle scroll strobe
//   o_obs_valid/pos/kind per-slot live flag, x position (slot 0 in LSBs), tree size
//   o_hit_zone           a live slot sits strictly inside the collision window
//   o_pass_pulse         one cycle: an obstacle crossed the dino line
//   o_spawn_pulse        one cycle: a slot was loaded
module obstacle_sched
  import dino_pkg::*;
#(
  parameter int unsigned      N_SLOTS = 4,
  parameter int unsigned      POS_W   = PosWDef,
  parameter logic [POS_W-1:0] SPAWN_X = POS_W'(SpawnXDef),
  parameter logic [POS_W-1:0] DINO_X  = POS_W'(DinoXDef),
  parameter logic [POS_W-1:0] HIT_LO  = POS_W'(HitLoDef),
  parameter logic [POS_W-1:0] HIT_HI  = POS_W'(HitHiDef),
  parameter logic [7:0]       MIN_GAP = MinGapDef,
  parameter logic [15:0]      SEED    = SeedDef
) (
  input  logic                     i_clk,
  input  logic                     i_clr,
  input  logic                     i_run,
  input  logic                     i_freeze,
  input  logic [1:0]               i_level,
  input  logic                     i_frame_tick,
  output logic [N_SLOTS-1:0]       o_obs_valid,
  output logic [N_SLOTS*POS_W-1:0] o_obs_pos,
  output logic [N_SLOTS-1:0]       o_obs_kind,
  output logic                     o_hit_zone,
  output logic                     o_pass_pulse,
  output logic                     o_spawn_pulse
);

  state_e             r_state, w_state_next;
  logic [N_SLOTS-1:0] r_valid, w_valid_next;
  logic [N_SLOTS-1:0] r_kind, w_kind_next;
  logic [POS_W-1:0]   r_pos [N_SLOTS];
  logic [POS_W-1:0]   w_pos_next [N_SLOTS];
  logic [8:0]         r_gap, w_gap_next;
  logic               r_hit, w_hit_next;
  logic               r_pass, w_pass_next;
  logic               r_spawn, w_spawn_next;

  logic [15:0]        w_lfsr;
  logic [2:0]         w_step;
  logic               w_scroll;
  logic [N_SLOTS-1:0] w_free_oh;
  logic [8:0]         w_gap_dec;
  logic               w_spawn_go;
  logic               w_hit_now;
  logic               w_unused_lfsr;

  lfsr16 u_lfsr (
    .i_clk  (i_clk),
    .i_clr  (i_clr),
    .i_seed (SEED),
    .o_q    (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:8];

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (i_run && !i_freeze) w_state_next = StRun;
      StRun: begin
        if (i_freeze)    w_state_next = StFrozen;
        else if (!i_run) w_state_next = StIdle;
      end
      StFrozen: if (!i_run && !i_freeze) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  assign w_step   = {1'b0, i_level} + 3'd1;
  assign w_scroll = (r_state == StRun) && i_frame_tick;

  // Lowest clear bit of r_valid as one-hot; zero when every slot is live.
  assign w_free_oh = ~r_valid & (r_valid + N_SLOTS'(1));

  assign w_gap_dec = (r_gap > 9'(w_step)) ? (r_gap - 9'(w_step)) : 9'd0;

  // Spawn when this step drains the gap (or it was already drained and pending).
  assign w_spawn_go = w_scroll && (w_gap_dec == 9'd0) && (|w_free_oh);

  always_comb begin
    w_hit_now = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (r_valid[i] && (r_pos[i] > HIT_LO) && (r_pos[i] < HIT_HI)) w_hit_now = 1'b1;
    end
  end

  // Slot array next state
  always_comb begin
    logic [POS_W-1:0] new_pos;
    w_valid_next = r_valid;
    w_kind_next  = r_kind;
    w_pos_next   = r_pos;
    w_gap_next   = r_gap;
    w_pass_next  = 1'b0;
    w_spawn_next = 1'b0;
    w_hit_next   = (r_state == StFrozen) ? r_hit : w_hit_now;
    new_pos      = '0;

    if (w_state_next == StIdle) begin
      w_valid_next = '0;
      w_kind_next  = '0;
      for (int i = 0; i < N_SLOTS; i++) w_pos_next[i] = '0;
      w_gap_next   = {1'b0, MIN_GAP};
      w_hit_next   = 1'b0;
    end else if (w_scroll) begin
      w_gap_next = w_gap_dec;
      for (int i = 0; i < N_SLOTS; i++) begin
        if (r_valid[i]) begin
          if (r_pos[i] < POS_W'(w_step)) begin
            w_valid_next[i] = 1'b0;
            w_pos_next[i]   = '0;
          end else begin
            new_pos       = r_pos[i] - POS_W'(w_step);
            w_pos_next[i] = new_pos;
            if ((r_pos[i] >= DINO_X) && (new_pos < DINO_X)) w_pass_next = 1'b1;
          end
        end
      end
      if (w_spawn_go) begin
        for (int i = 0; i < N_SLOTS; i++) begin
          if (w_free_oh[i]) begin
            w_valid_next[i] = 1'b1;
            w_pos_next[i]   = SPAWN_X;
            w_kind_next[i]  = w_lfsr[0];
          end
        end
        w_gap_next   = gap_reload(MIN_GAP, w_lfsr[7:1], i_level);
        w_spawn_next = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= StIdle;
      r_valid <= '0;
      r_kind  <= '0;
      for (int i = 0; i < N_SLOTS; i++) r_pos[i] <= '0;
      r_gap   <= {1'b0, MIN_GAP};
      r_hit   <= 1'b0;
      r_pass  <= 1'b0;
      r_spawn <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_valid_next;
      r_kind  <= w_kind_next;
      for (int i = 0; i < N_SLOTS; i++) r_pos[i] <= w_pos_next[i];
      r_gap   <= w_gap_next;
      r_hit   <= w_hit_next;
      r_pass  <= w_pass_next;
      r_spawn <= w_spawn_next;
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_pos
    assign o_obs_pos[g*POS_W +: POS_W] = r_pos[g];
  end

  assign o_obs_valid   = r_valid;
  assign o_obs_kind    = r_kind;
  assign o_hit_zone    = r_hit;
  assign o_pass_pulse  = r_pass;
  assign o_spawn_pulse = r_spawn;

endmodule

// File: tb/tb_obstacle_sched.sv
// Self-checking bench for obstacle_sched: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of the obstacle field.
module tb_obstacle_sched;

  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0, run = 1'b0, freeze = 1'b0, tick = 1'b0;
  logic [1:0]    level = 2'd0;
  logic [NS-1:0] obs_valid, obs_kind;
  logic [NS*9-1:0] obs_pos;
  logic          hit_zone, pass_pulse, spawn_pulse;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  // Behavioural model: 0 idle, 1 run, 2 frozen
  int m_state;
  bit m_valid [NS];
  int m_pos   [NS];
  bit m_kind  [NS];
  int m_gap;
  int m_lfsr;
  bit m_hit, m_pass, m_spawn;

  always #5 clk = ~clk;

  obstacle_sched dut (
    .i_clk         (clk),
    .i_clr         (clr),
    .i_run         (run),
    .i_freeze      (freeze),
    .i_level       (level),
    .i_frame_tick  (tick),
    .o_obs_valid   (obs_valid),
    .o_obs_pos     (obs_pos),
    .o_obs_kind    (obs_kind),
    .o_hit_zone    (hit_zone),
    .o_pass_pulse  (pass_pulse),
    .o_spawn_pulse (spawn_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pos_of(input int i);
    logic [8:0] p;
    p = obs_pos[i*9 +: 9];
    return int'(p);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0; m_pos[i] = 0; m_kind[i] = 0;
    end
    m_gap = 120;
    m_hit = 0;
  endtask

  task automatic model_step(input bit c, input bit r, input bit f, input int lv, input bit t);
    int nxt, step, old_l, fb, free;
    bit hit_now;
    m_pass  = 0;
    m_spawn = 0;
    if (c) begin
      m_state = 0;
      model_clear();
      m_lfsr = 'hACE1;
    end else begin
      nxt = m_state;
      if (m_state == 0 && r && !f) nxt = 1;
      if (m_state == 1 && f) nxt = 2;
      if (m_state == 1 && !f && !r) nxt = 0;
      if (m_state == 2 && !r && !f) nxt = 0;
      old_l  = m_lfsr;
      fb     = ((old_l >> 15) ^ (old_l >> 13) ^ (old_l >> 12) ^ (old_l >> 10)) & 1;
      m_lfsr = ((old_l << 1) | fb) & 'hFFFF;
      hit_now = 0;
      for (int i = 0; i < NS; i++)
        if (m_valid[i] && m_pos[i] > 401 && m_pos[i] < 469) hit_now = 1;
      if (nxt == 0) begin
        model_clear();
      end else begin
        if (m_state == 1 && t) begin
          step = lv + 1;
          free = -1;
          for (int i = NS - 1; i >= 0; i--) if (!m_valid[i]) free = i;
          for (int i = 0; i < NS; i++) begin
            if (m_valid[i]) begin
              if (m_pos[i] < step) begin
                m_valid[i] = 0; m_pos[i] = 0;
              end else begin
                if (m_pos[i] >= 400 && m_pos[i] - step < 400) m_pass = 1;
                m_pos[i] -= step;
              end
            end
          end
          m_gap -= step;
          if (m_gap < 0) m_gap = 0;
          if (m_gap == 0 && free >= 0) begin
            m_valid[free] = 1;
            m_pos[free]   = 479;
            m_kind[free]  = old_l & 1;
            m_gap = 120 + ((old_l >> 1) & 127) - 16 * lv;
            if (m_gap < 60) m_gap = 60;
            m_spawn = 1;
          end
        end
        if (m_state != 2) m_hit = hit_now;
      end
      m_state = nxt;
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      logic [NS-1:0] ev, ek;
      for (int i = 0; i < NS; i++) begin
        ev[i] = m_valid[i];
        ek[i] = m_kind[i];
        check($sformatf("pos%0d", i), pos_of(i), m_pos[i]);
      end
      check("valid", obs_valid, ev);
      check("kind", obs_kind, ek);
      check("hit_zone", hit_zone, m_hit);
      check("pass_pulse", pass_pulse, m_pass);
      check("spawn_pulse", spawn_pulse, m_spawn);
    end
  end

  task automatic drive(input bit c, input bit r, input bit f, input int lv, input bit t);
    @(negedge clk);
    clr = c; run = r; freeze = f; level = lv[1:0]; tick = t;
    @(posedge clk);
    model_step(c, r, f, lv, t);
  endtask

  // One quiet cycle then one tick cycle; returns just after the tick's edge.
  task automatic do_tick(input bit r, input bit f, input int lv);
    drive(0, r, f, lv, 0);
    drive(0, r, f, lv, 1);
    #1;
  endtask

  task automatic drive_slot(input int idx, input int target);
    int d;
    for (int n = 0; n < 3000 && m_valid[idx] && m_pos[idx] > target; n++) begin
      d = m_pos[idx] - target;
      do_tick(1, 0, (d >= 4) ? 3 : d - 1);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r;
    bit found;

    // 1. reset, first spawn after 120 pixels at level 0
    drive(1, 0, 0, 0, 0);
    checking = 1;
    drive(1, 0, 0, 0, 0);
    #1;
    check("rst_valid", obs_valid, 0);
    check("rst_pos", obs_pos, 0);
    check("rst_kind", obs_kind, 0);
    check("rst_hit", hit_zone, 0);
    check("rst_pulses", {pass_pulse, spawn_pulse}, 0);
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 119; i++) do_tick(1, 0, 0);
    check("t1_no_early_spawn", spawn_pulse, 0);
    do_tick(1, 0, 0);
    check("t1_spawn", spawn_pulse, 1);
    check("t1_valid0", obs_valid[0], 1);
    check("t1_pos0", pos_of(0), 479);

    // 2. level 3 retire without wrap
    drive_slot(0, 6);
    check("t2_pos6", pos_of(0), 6);
    do_tick(1, 0, 3);
    check("t2_pos2", pos_of(0), 2);
    do_tick(1, 0, 3);
    check("t2_retired", obs_valid[0], 0);
    check("t2_pos0", pos_of(0), 0);

    // 3. pass line crossing
    k = -1;
    for (int n = 0; n < 600 && k < 0; n++) begin
      for (int i = 0; i < NS; i++) if (k < 0 && m_valid[i] && m_pos[i] >= 403) k = i;
      if (k < 0) do_tick(1, 0, 0);
    end
    if (k < 0) begin
      checks++; errors++;
      $display("FAIL t3_find: got none expected slot above 402");
    end else begin
      drive_slot(k, 402);
      do_tick(1, 0, 1);
      check("t3_pos400", pos_of(k), 400);
      check("t3_no_pass", pass_pulse, 0);
      do_tick(1, 0, 1);
      check("t3_pos398", pos_of(k), 398);
      check("t3_pass", pass_pulse, 1);
      drive(0, 1, 0, 1, 0);
      #1;
      check("t3_pass_once", pass_pulse, 0);
    end

    // 4. all slots full with a pending spawn
    found = 0;
    for (int n = 0; n < 15000 && !found; n++) begin
      do_tick(1, 0, 3);
      if (m_valid[0] && m_valid[1] && m_valid[2] && m_valid[3] && m_gap == 0) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL t4_full: got not reached expected full with gap 0");
    end else begin
      check("t4_full", obs_valid, 4'hF);
      check("t4_no_spawn", spawn_pulse, 0);
      r = -1;
      for (int n = 0; n < 300 && r < 0; n++) begin
        do_tick(1, 0, 3);
        for (int i = 0; i < NS; i++) if (r < 0 && !m_valid[i]) r = i;
      end
      if (r < 0) begin
        checks++; errors++;
        $display("FAIL t4_retire: got none expected a retirement");
      end else begin
        check("t4_retire_no_spawn", spawn_pulse, 0);
        check("t4_retired", obs_valid[r], 0);
        do_tick(1, 0, 3);
        check("t4_late_spawn", spawn_pulse, 1);
        check("t4_slot_reused", obs_valid[r], 1);
        check("t4_slot_pos", pos_of(r), 479);
      end
    end

    // 5. freeze holds field, release returns to idle
    drive(0, 0, 0, 0, 0);
    #1;
    check("t5_idle_clear", obs_valid, 0);
    for (int n = 0; n < 200 && !m_valid[0]; n++) do_tick(1, 0, 0);
    drive_slot(0, 430);
    check("t5_pos430", pos_of(0), 430);
    for (int n = 0; n < 50; n++) do_tick(1, 1, 0);
    check("t5_frozen_pos", pos_of(0), 430);
    check("t5_frozen_hit", hit_zone, 1);
    drive(0, 0, 0, 0, 0);
    #1;
    check("t5_release_valid", obs_valid, 0);
    check("t5_release_hit", hit_zone, 0);

    // 6. clr on a tick cycle while running
    drive(0, 1, 0, 0, 0);
    for (int n = 0; n < 130; n++) do_tick(1, 0, 0);
    drive(1, 1, 0, 2, 1);
    #1;
    check("t6_valid", obs_valid, 0);
    check("t6_pulses", {pass_pulse, spawn_pulse}, 0);
    check("t6_pos", obs_pos, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 1);

    // Randomized phase
    for (int n = 0; n < 4000; n++) begin
      drive(($urandom % 500) == 0, ($urandom % 25) != 0, ($urandom % 40) == 0,
            int'($urandom % 4), ($urandom % 2) == 0);
    end

    @(negedge clk);
    checking = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
